x_iobuf_ctrl: RTL and testbench



---
 rtl/x_iobuf_ctrl_pkg.sv | 16 +
 rtl/x_iobuf_cell.sv | 50 +++++
 rtl/x_iobuf_ctrl.sv | 145 ++++++++++++++
 tb/tb_x_iobuf_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/x_iobuf_ctrl_pkg.sv
// Shared definitions for the registered bidirectional pad controller:
// direction-state encoding and the recognised device-series names.
package x_iobuf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HIZ      = 2'd0,
    ST_TURN_ON  = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_TURN_OFF = 2'd3
  } dir_state_e;

  localparam SER_7 = "7SERIRE";
  localparam SER_5 = "5SERIRE";
  localparam SER_4 = "4SERIRE";

endpackage

// File: rtl/x_iobuf_cell.sv
// One pad bit: IOBUF (single-ended) or IOBUFDS (differential) behaviour,
// selected per device series and mode, with per-series parameter checks.
module x_iobuf_cell
  import x_iobuf_ctrl_pkg::*;
#(
  parameter     FPGA_SERIES  = "7SERIRE",
  parameter     PHYSICS_MODE = "SINGLE",
  parameter     IOSTANDARD   = "DEFAULT",
  parameter     SLEW         = "SLOW",
  parameter int DRIVE        = 12
) (
  input  logic dout,
  input  logic tri_en,
  output logic din,
  inout  wire  pad_p,
  inout  wire  pad_n
);

  localparam bit SER_OK = (FPGA_SERIES == SER_7) || (FPGA_SERIES == SER_5) ||
                          (FPGA_SERIES == SER_4);

  if (IOSTANDARD == 0) begin : g_bad_iostd
    $error("x_iobuf_cell: IOSTANDARD must name a standard");
  end

  if (!SER_OK) begin : g_bad_series
    $error("x_iobuf_cell: unsupported FPGA_SERIES");
  end else if (PHYSICS_MODE == "SINGLE") begin : g_se
    if (DRIVE < 2 || DRIVE > 24) begin : g_bad_drive
      $error("x_iobuf_cell: DRIVE out of range");
    end
    if (SLEW != "SLOW" && SLEW != "FAST") begin : g_bad_slew
      $error("x_iobuf_cell: SLEW must be SLOW or FAST");
    end
    assign pad_p = tri_en ? 1'bz : dout;
    assign pad_n = 1'bz;
  end else if (PHYSICS_MODE == "DIFF") begin : g_ds
    // Only the 7-series differential buffer takes a slew setting.
    if (FPGA_SERIES == SER_7 && SLEW != "SLOW" && SLEW != "FAST") begin : g_bad_slew
      $error("x_iobuf_cell: SLEW must be SLOW or FAST");
    end
    assign pad_p = tri_en ? 1'bz : dout;
    assign pad_n = tri_en ? 1'bz : ~dout;
  end else begin : g_bad_mode
    $error("x_iobuf_cell: PHYSICS_MODE must be SINGLE or DIFF");
  end

  assign din = pad_p;

endmodule

// File: rtl/x_iobuf_ctrl.sv
// Direction-managed bidirectional bus controller: tristate FSM with dead-cycle
// turnaround, IOB output/tristate registers and a settled-input qualifier.
module x_iobuf_ctrl
  import x_iobuf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter     FPGA_SERIES  = "7SERIRE",
  parameter     PHYSICS_MODE = "SINGLE",
  parameter     IOSTANDARD   = "DEFAULT",
  parameter     SLEW         = "SLOW",
  parameter int DRIVE        = 12,
  parameter int TURN_CYCLES  = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drive_req,
  output logic                  drive_ack,
  output logic [1:0]            dir_state,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  inout  wire  [DATA_WIDTH-1:0] pad_p,
  inout  wire  [DATA_WIDTH-1:0] pad_n
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
    $error("x_iobuf_ctrl: DATA_WIDTH must be 1..64");
  end
  if (TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("x_iobuf_ctrl: TURN_CYCLES must be 0..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("x_iobuf_ctrl: SYNC_STAGES must be 2..4");
  end

  localparam logic [3:0] CNT_LAST = (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
  localparam logic [2:0] SETTLE   = 3'(SYNC_STAGES);

  dir_state_e st;
  logic [3:0] cnt;
  logic [2:0] settle;

  (* IOB = "TRUE" *) logic [DATA_WIDTH-1:0] out_q;
  (* IOB = "TRUE" *) logic [DATA_WIDTH-1:0] tri_q;

  logic [DATA_WIDTH-1:0]                  pad_in;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;

  // Outputs are set on the transition into each state so they stay registered
  // and never see drive_req combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_HIZ;
      cnt       <= '0;
      settle    <= '0;
      drive_ack <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      out_q     <= '0;
      tri_q     <= '1;
    end else begin
      case (st)
        ST_HIZ: begin
          if (drive_req) begin
            cnt      <= '0;
            settle   <= '0;
            rx_valid <= 1'b0;
            if (TURN_CYCLES == 0) begin
              st        <= ST_DRIVE;
              drive_ack <= 1'b1;
              tx_ready  <= 1'b1;
              tri_q     <= '0;
            end else begin
              st <= ST_TURN_ON;
            end
          end else begin
            if (settle != SETTLE) settle <= settle + 3'd1;
            rx_valid <= (settle >= SETTLE - 3'd1);
          end
        end
        ST_TURN_ON: begin
          if (!drive_req) begin
            st     <= ST_HIZ;
            settle <= '0;
          end else if (cnt == CNT_LAST) begin
            st        <= ST_DRIVE;
            drive_ack <= 1'b1;
            tx_ready  <= 1'b1;
            tri_q     <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DRIVE: begin
          if (tx_valid) out_q <= tx_data;
          if (!drive_req) begin
            drive_ack <= 1'b0;
            tx_ready  <= 1'b0;
            tri_q     <= '1;
            cnt       <= '0;
            settle    <= '0;
            st        <= (TURN_CYCLES == 0) ? ST_HIZ : ST_TURN_OFF;
          end
        end
        default: begin
          if (cnt == CNT_LAST) begin
            st     <= ST_HIZ;
            settle <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Free-running input synchroniser on every bit, independent of direction.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
  end

  assign rx_data   = sync_q[SYNC_STAGES-1];
  assign dir_state = st;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
    x_iobuf_cell #(
      .FPGA_SERIES  (FPGA_SERIES),
      .PHYSICS_MODE (PHYSICS_MODE),
      .IOSTANDARD   (IOSTANDARD),
      .SLEW         (SLEW),
      .DRIVE        (DRIVE)
    ) u_cell (
      .dout   (out_q[g]),
      .tri_en (tri_q[g]),
      .din    (pad_in[g]),
      .pad_p  (pad_p[g]),
      .pad_n  (pad_n[g])
    );
  end

endmodule

// File: tb/tb_x_iobuf_ctrl.sv
// Random/directed bench for x_iobuf_ctrl: a 16-bit single-ended instance and an
// 8-bit differential instance run against a phase/age reference model.
module tb_x_iobuf_ctrl;

  localparam int TC0 = 2, SS0 = 2;
  localparam int TC1 = 0, SS1 = 3;
  localparam int M_HZ = 0, M_ON = 1, M_DRV = 2, M_OFF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drive_req = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;

  logic        ack0, rdy0, rxv0, ack1, rdy1, rxv1;
  logic [1:0]  ds0, ds1;
  logic [15:0] rxd0;
  logic [7:0]  rxd1;
  wire  [15:0] pad_p0, pad_n0;
  wire  [7:0]  pad_p1, pad_n1;

  logic        xe [2];
  logic [15:0] xv [2];

  int ph [2], left [2], age [2];
  logic [15:0] outr [2];
  logic [15:0] rxq [2][$];

  int n_chk = 0, n_err = 0, cyc_no = 0;

  always #5 clk = ~clk;

  assign pad_p0 = xe[0] ? xv[0] : 16'hzzzz;
  assign pad_p1 = xe[1] ? xv[1][7:0] : 8'hzz;
  assign pad_n1 = xe[1] ? ~xv[1][7:0] : 8'hzz;

  x_iobuf_ctrl #(.DATA_WIDTH(16), .FPGA_SERIES("7SERIRE"), .PHYSICS_MODE("SINGLE"),
                 .TURN_CYCLES(TC0), .SYNC_STAGES(SS0)) u_dut0 (
    .clk(clk), .rst(rst), .drive_req(drive_req), .drive_ack(ack0), .dir_state(ds0),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy0), .rx_data(rxd0),
    .rx_valid(rxv0), .pad_p(pad_p0), .pad_n(pad_n0));

  x_iobuf_ctrl #(.DATA_WIDTH(8), .FPGA_SERIES("7SERIRE"), .PHYSICS_MODE("DIFF"),
                 .TURN_CYCLES(TC1), .SYNC_STAGES(SS1)) u_dut1 (
    .clk(clk), .rst(rst), .drive_req(drive_req), .drive_ack(ack1), .dir_state(ds1),
    .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy1), .rx_data(rxd1),
    .rx_valid(rxv1), .pad_p(pad_p1), .pad_n(pad_n1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_no, obs, exp);
    end
  endtask

  // Pad seen during the cycle that just ended: ours when driving, else the external one.
  task automatic model_step(input int k, input int tc, input int ss, input logic [15:0] m);
    logic [15:0] smp;
    smp = ((ph[k] == M_DRV) ? outr[k] : xv[k]) & m;
    if (rst) begin
      ph[k] = M_HZ; left[k] = 0; age[k] = 0; outr[k] = '0;
      rxq[k].delete();
    end else begin
      rxq[k].push_front(smp);
      if (rxq[k].size() > ss) void'(rxq[k].pop_back());
      case (ph[k])
        M_HZ: begin
          age[k]++;
          if (drive_req) begin
            if (tc == 0) ph[k] = M_DRV;
            else begin ph[k] = M_ON; left[k] = tc; end
          end
        end
        M_ON: begin
          if (!drive_req) begin ph[k] = M_HZ; age[k] = 0; end
          else begin left[k]--; if (left[k] == 0) ph[k] = M_DRV; end
        end
        M_DRV: begin
          if (tx_valid) outr[k] = tx_data & m;
          if (!drive_req) begin
            if (tc == 0) begin ph[k] = M_HZ; age[k] = 0; end
            else begin ph[k] = M_OFF; left[k] = tc; end
          end
        end
        default: begin
          left[k]--;
          if (left[k] == 0) begin ph[k] = M_HZ; age[k] = 0; end
        end
      endcase
    end
  endtask

  task automatic chk_inst(input int k, input int ss, input logic [15:0] m, input logic diff,
                          input logic [1:0] ds, input logic ack, input logic rdy,
                          input logic rxv, input logic [15:0] rxd,
                          input logic [15:0] pp, input logic [15:0] pn);
    logic [15:0] exp_pad, exp_rx;
    string p;
    p = $sformatf("u%0d.", k);
    exp_pad = ((ph[k] == M_DRV) ? outr[k] : xv[k]) & m;
    exp_rx  = (rxq[k].size() >= ss) ? rxq[k][ss-1] : 16'h0;
    chk({p, "dir_state"}, 64'(ds), 64'(ph[k]));
    chk({p, "drive_ack"}, 64'(ack), 64'(ph[k] == M_DRV));
    chk({p, "tx_ready"}, 64'(rdy), 64'(ph[k] == M_DRV));
    chk({p, "rx_valid"}, 64'(rxv), 64'(ph[k] == M_HZ && age[k] >= ss));
    chk({p, "rx_data"}, 64'(rxd), 64'(exp_rx));
    chk({p, "pad_p"}, 64'(pp & m), 64'(exp_pad));
    if (diff) chk({p, "pad_n"}, 64'(pn & m), 64'(~exp_pad & m));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc_no++;
    model_step(0, TC0, SS0, 16'hFFFF);
    model_step(1, TC1, SS1, 16'h00FF);
    #1;
    xe[0] = (ph[0] != M_DRV);
    xe[1] = (ph[1] != M_DRV);
    #1;
    chk_inst(0, SS0, 16'hFFFF, 1'b0, ds0, ack0, rdy0, rxv0, rxd0, pad_p0, 16'h0);
    chk_inst(1, SS1, 16'h00FF, 1'b1, ds1, ack1, rdy1, rxv1, {8'h0, rxd1},
             {8'h0, pad_p1}, {8'h0, pad_n1});
  endtask

  task automatic cyc(input logic r, input logic req, input logic v, input logic [15:0] d,
                     input logic [15:0] ext);
    rst = r; drive_req = req; tx_valid = v; tx_data = d;
    xv[0] = ext; xv[1] = ext & 16'h00FF;
    tick();
  endtask

  initial begin
    xe[0] = 1'b1; xe[1] = 1'b1; xv[0] = 16'hA5A5; xv[1] = 16'h00A5;
    for (int k = 0; k < 2; k++) begin ph[k] = M_HZ; left[k] = 0; age[k] = 0; outr[k] = '0; end

    // reset, then settle onto a pulled-up A5A5 bus
    repeat (3) cyc(1, 0, 0, 16'h0, 16'hA5A5);
    repeat (5) cyc(0, 0, 0, 16'h0, 16'hA5A5);
    // aborted turn-on
    cyc(0, 1, 0, 16'h0, 16'h5A5A);
    repeat (4) cyc(0, 0, 0, 16'h0, 16'h5A5A);
    // turn-on, one accepted word, turn-off
    repeat (3) cyc(0, 1, 0, 16'h0, 16'h0F0F);
    cyc(0, 1, 1, 16'h1234, 16'h0F0F);
    repeat (2) cyc(0, 1, 0, 16'hDEAD, 16'h0F0F);
    repeat (7) cyc(0, 0, 0, 16'h0, 16'h0000);
    // reset while driving all ones
    repeat (3) cyc(0, 1, 0, 16'h0, 16'h0000);
    cyc(0, 1, 1, 16'hFFFF, 16'h0000);
    cyc(0, 1, 0, 16'h0, 16'h0000);
    cyc(1, 1, 0, 16'h0, 16'h0000);
    repeat (4) cyc(0, 0, 0, 16'h0, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      logic req_n;
      req_n = ($urandom_range(0, 4) == 0) ? ~drive_req : drive_req;
      cyc(($urandom_range(0, 149) == 0), req_n, 1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
